// File: rtl/uart_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_receiver_if
// Groups the serial line and the byte-delivery outputs of uart_receiver.
//   RX        : serial line into the receiver (idles high)
//   data_out  : last correctly received byte
//   done      : one-cycle pulse, data_out updated this cycle
//   frame_err : one-cycle pulse, stop bit sampled low, byte discarded
//   busy      : receiver is not idle
// master : line driver / byte consumer side
// slave  : the receiver itself
// ---------------------------------------------------------------------------
interface uart_receiver_if;
    logic       RX;
    logic [7:0] data_out;
    logic       done;
    logic       frame_err;
    logic       busy;

    modport master (
        output RX,
        input  data_out,
        input  done,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  RX,
        output data_out,
        output done,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// Receives 10-bit UART frames (start 0, 8 data bits MSB first, stop 1) on an
// oversampling clock. Each good byte is presented with a one-cycle done
// pulse; a low stop bit produces a one-cycle frame_err pulse instead.
//
// Parameters:
//   OVERSAMPLE : rx_clk cycles per bit period (even, >= 4)
// Ports:
//   rx_clk : oversampling clock, all state updates on its rising edge
//   rst    : asynchronous active-high reset
//   bus    : uart_receiver_if.slave (RX in; data_out/done/frame_err/busy out)
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic              rx_clk,
    input  logic              rst,
    uart_receiver_if.slave    bus
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_rx_s1;
    logic          r_rx_s2;
    logic          r_rx_prev;
    logic [CW-1:0] r_os_cnt;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shreg;
    logic [7:0]    r_data_out;
    logic          r_done;
    logic          r_frame_err;
    logic          r_busy;

    logic          w_cnt_clr;
    logic          w_bit_clr;
    logic          w_shift;
    logic          w_load;
    logic          w_ferr;

    // Two-stage synchronizer plus previous-value register for edge detect.
    // Reset to the idle line level so reset release never looks like an edge.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= bus.RX;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // State register
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath controls
    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        w_bit_clr = 1'b0;
        w_shift   = 1'b0;
        w_load    = 1'b0;
        w_ferr    = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Only a 1->0 transition starts a frame; a line held low
                // (e.g. a break after a framing error) is ignored.
                if (r_rx_prev && !r_rx_s2) begin
                    w_next    = START;
                    w_cnt_clr = 1'b1;
                end
            end
            START: begin
                if (r_os_cnt == HALF_M1) begin
                    w_cnt_clr = 1'b1;
                    if (!r_rx_s2) begin
                        w_next    = DATA;
                        w_bit_clr = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (r_os_cnt == FULL_M1) begin
                    w_shift   = 1'b1;
                    w_cnt_clr = 1'b1;
                    if (r_bit_cnt == 4'd7) begin
                        w_next = STOP;
                    end
                end
            end
            STOP: begin
                if (r_os_cnt == FULL_M1) begin
                    w_cnt_clr = 1'b1;
                    w_next    = IDLE;
                    if (r_rx_s2) begin
                        w_load = 1'b1;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end
            end
            default: begin
                w_next    = IDLE;
                w_cnt_clr = 1'b1;
            end
        endcase
    end

    // Counters, shift register and registered outputs
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_data_out  <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_os_cnt <= '0;
            end else begin
                r_os_cnt <= r_os_cnt + 1'b1;
            end

            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            // MSB first: the earliest bit ends up in bit 7
            if (w_shift) begin
                r_shreg <= {r_shreg[6:0], r_rx_s2};
            end

            if (w_load) begin
                r_data_out <= r_shreg;
            end

            r_done      <= w_load;
            r_frame_err <= w_ferr;
            // Rises the cycle after START is entered; drops on the same edge
            // that returns to IDLE, so it falls together with done/frame_err.
            r_busy      <= (r_state != IDLE) && (w_next != IDLE);
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.done      = r_done;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    localparam int OS      = 16;
    localparam int LATENCY = 3 + OS / 2 + 9 * OS;  // start drive -> pulse visible

    logic rx_clk = 1'b0;
    logic rst    = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    uart_receiver_if u_if ();

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .rx_clk (rx_clk),
        .rst    (rst),
        .bus    (u_if)
    );

    always #5 rx_clk = ~rx_clk;
    always @(posedge rx_clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         at;
    } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    logic [7:0] model_last = 8'h00;
    logic       prev_pulse = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Event monitor: records pulses and checks the always-true output rules
    always @(negedge rx_clk) begin
        if (rst) begin
            prev_pulse <= 1'b0;
            prev_data  <= u_if.data_out;
        end else begin
            chk("pulse_exclusive", 32'(u_if.done & u_if.frame_err), 0);
            if (prev_pulse) chk("pulse_consecutive", 32'(u_if.done | u_if.frame_err), 0);
            if (!u_if.done) chk("data_out_stable", 32'(u_if.data_out), 32'(prev_data));
            if (u_if.done || u_if.frame_err) begin
                chk("busy_at_pulse", 32'(u_if.busy), 0);
                obs_q.push_back('{u_if.frame_err, u_if.data_out, cyc});
            end
            prev_pulse <= u_if.done | u_if.frame_err;
            prev_data  <= u_if.data_out;
        end
    end

    // Drives the first nbits bits of a frame; bit i lasts p_even or p_odd cycles.
    // A complete frame adds its predicted outcome to the expectation queue.
    task automatic send_frame(input logic [7:0] b, input bit stop,
                              input int p_even, input int p_odd, input int nbits);
        int c;
        bit v;
        c = cyc;
        if (nbits == 10) begin
            exp_q.push_back('{!stop, stop ? b : model_last, c + LATENCY});
            if (stop) model_last = b;
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == 0)      v = 1'b0;
            else if (i == 9) v = stop;
            else             v = bit'((b >> (8 - i)) & 8'd1);
            u_if.RX = v;
            repeat ((i % 2) ? p_odd : p_even) @(negedge rx_clk);
        end
    endtask

    task automatic drain();
        ev_t e;
        ev_t o;
        int  t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = 0;
            while (obs_q.size() == 0 && t < 400) begin
                @(negedge rx_clk);
                t++;
            end
            if (obs_q.size() == 0) begin
                chk("event_timeout", 32'(obs_q.size()), 1);
            end else begin
                o = obs_q.pop_front();
                chk("event_kind", 32'(o.is_err), 32'(e.is_err));
                chk("event_data", 32'(o.data), 32'(e.data));
                chk("event_cycle", 32'(o.at), 32'(e.at));
            end
        end
    endtask

    task automatic quiet(input int n);
        repeat (n) @(negedge rx_clk);
        chk("no_spurious_event", 32'(obs_q.size()), 0);
        chk("data_out_hold", 32'(u_if.data_out), 32'(model_last));
        chk("busy_idle", 32'(u_if.busy), 0);
    endtask

    initial begin
        int         c;
        logic [7:0] rb;
        logic [7:0] part;
        u_if.RX = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(negedge rx_clk);
        chk("reset_data_out", 32'(u_if.data_out), 0);
        chk("reset_done", 32'(u_if.done), 0);
        chk("reset_frame_err", 32'(u_if.frame_err), 0);
        chk("reset_busy", 32'(u_if.busy), 0);
        rst = 1'b0;
        repeat (4) @(negedge rx_clk);

        // Single byte
        send_frame(8'hA5, 1'b1, OS, OS, 10);
        drain();
        quiet(20);

        // Random bytes with random idle gaps
        for (int n = 0; n < 6; n++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1, OS, OS, 10);
            drain();
            repeat ($urandom_range(0, 30)) @(negedge rx_clk);
        end
        quiet(10);

        // Back-to-back, no idle gap
        send_frame(8'h00, 1'b1, OS, OS, 10);
        send_frame(8'hFF, 1'b1, OS, OS, 10);
        drain();
        quiet(20);

        // Glitch rejection
        c = cyc;
        u_if.RX = 1'b0;
        repeat (4) @(negedge rx_clk);
        u_if.RX = 1'b1;
        repeat (2) @(negedge rx_clk);
        chk("glitch_busy_high", 32'(u_if.busy), 1);
        chk("glitch_cycle_ref", 32'(cyc - c), 6);
        quiet(30);

        // Framing error followed by a held-low line, then a good frame
        send_frame(8'h3C, 1'b0, OS, OS, 10);
        repeat (40) @(negedge rx_clk);
        drain();
        chk("no_frame_in_break", 32'(u_if.busy), 0);
        u_if.RX = 1'b1;
        quiet(20);
        send_frame(8'h81, 1'b1, OS, OS, 10);
        drain();
        quiet(20);

        // Reset during data bit 4
        part = 8'h5A;
        send_frame(part, 1'b1, OS, OS, 4);
        u_if.RX = part[4];
        repeat (8) @(negedge rx_clk);
        rst = 1'b1;
        #1;
        chk("midreset_data_out", 32'(u_if.data_out), 0);
        chk("midreset_done", 32'(u_if.done), 0);
        chk("midreset_frame_err", 32'(u_if.frame_err), 0);
        chk("midreset_busy", 32'(u_if.busy), 0);
        model_last = 8'h00;
        u_if.RX = 1'b1;
        repeat (3) @(negedge rx_clk);
        rst = 1'b0;
        quiet(10);
        send_frame(8'hC3, 1'b1, OS, OS, 10);
        drain();
        quiet(20);

        // Baud skew: slow (16/17 alternating) and fast (16/15 alternating)
        send_frame(8'h96, 1'b1, OS, OS + 1, 10);
        drain();
        quiet(20);
        send_frame(8'h96, 1'b1, OS, OS - 1, 10);
        drain();
        quiet(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
